// File: rtl/clock_chain_ctrl.sv
// Sequencer and set-mode controller for the sec/min/hour count_gate chain; optional auto-repeat via CLOCK_CTRL_AUTOREPEAT_EN.
// Latency: counter-control pulses one cycle after tick_1hz (RUN) or button rising edge (set modes); carries combinational.
// Backpressure: none; counters accept one en pulse per cycle and every step is issued unconditionally.
module clock_chain_ctrl #(
    parameter int CNT_W         = 24,
    parameter int REPEAT_DELAY  = 12_000_000,
    parameter int REPEAT_PERIOD = 3_000_000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       done_inc_sec,
    input  logic       done_inc_min,
    input  logic       done_inc_hour,
    output logic       en_sec,
    output logic       inc_sec,
    output logic       dec_sec,
    output logic       en_min,
    output logic       inc_min,
    output logic       dec_min,
    output logic       en_hour,
    output logic       inc_hour,
    output logic       dec_hour,
    output logic [1:0] mode,
    output logic       blink,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_t;

    // Last tick count before a set mode falls back to RUN.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT_TICKS - 1);

    mode_t      mode_q;
    logic       blink_q;
    logic [3:0] to_cnt;
    logic       btn_mode_q;
    logic       btn_up_q;
    logic       btn_down_q;
    logic       step_q;
    logic       up_q;
    logic       dn_q;

    logic       mode_ev;
    logic       up_ev;
    logic       dn_ev;
    logic       in_set;
    logic       one_held;
    logic       rpt_step;
    logic       activity;
    logic       up_req;
    logic       dn_req;
    mode_t      mode_nxt;

    assign mode_ev  = btn_mode & ~btn_mode_q;
    assign up_ev    = btn_up & ~btn_up_q;
    assign dn_ev    = btn_down & ~btn_down_q;
    assign in_set   = (mode_q != RUN);
    assign one_held = btn_up ^ btn_down;

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    // After the first repeat the counter restarts so the next hit lands REPEAT_PERIOD cycles later.
    localparam logic [CNT_W-1:0] RPT_HIT    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_hit;

    assign rpt_hit  = (rpt_cnt == RPT_HIT);
    assign rpt_step = in_set & one_held & rpt_hit & ~mode_ev;

    // Hold-time counter: runs only while exactly one of up/down is held in a set mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt <= '0;
        end else if (!in_set || !one_held || mode_ev) begin
            rpt_cnt <= '0;
        end else if (rpt_hit) begin
            rpt_cnt <= RPT_RELOAD;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    logic unused_rpt_cfg;

    assign rpt_step       = 1'b0;
    assign unused_rpt_cfg = ^{32'(CNT_W), 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    assign activity = mode_ev | up_ev | dn_ev | rpt_step;

    // A mode press drops any simultaneous step; both buttons held also suppresses stepping.
    assign up_req = in_set & ~mode_ev & btn_up & ~btn_down & (up_ev | rpt_step);
    assign dn_req = in_set & ~mode_ev & btn_down & ~btn_up & (dn_ev | rpt_step);

    // Next mode in the RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN cycle.
    always_comb begin
        mode_nxt = RUN;
        case (mode_q)
            RUN:      mode_nxt = SET_HOUR;
            SET_HOUR: mode_nxt = SET_MIN;
            SET_MIN:  mode_nxt = SET_SEC;
            default:  mode_nxt = RUN;
        endcase
    end

    // Mode FSM with blink phase and inactivity timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= RUN;
            blink_q <= 1'b0;
            to_cnt  <= 4'd0;
        end else if (mode_ev) begin
            mode_q  <= mode_nxt;
            blink_q <= (mode_nxt != RUN);
            to_cnt  <= 4'd0;
        end else if (in_set && tick_1hz && !activity && to_cnt == TO_LAST) begin
            mode_q  <= RUN;
            blink_q <= 1'b0;
            to_cnt  <= 4'd0;
        end else if (in_set) begin
            if (activity) begin
                to_cnt <= 4'd0;
            end else if (tick_1hz) begin
                to_cnt <= to_cnt + 4'd1;
            end
            if (tick_1hz) begin
                blink_q <= ~blink_q;
            end
        end else begin
            blink_q <= 1'b0;
            to_cnt  <= 4'd0;
        end
    end

    // Button history and the registered step requests that drive the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_mode_q <= 1'b0;
            btn_up_q   <= 1'b0;
            btn_down_q <= 1'b0;
            step_q     <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_up_q   <= btn_up;
            btn_down_q <= btn_down;
            step_q     <= tick_1hz & ~in_set;
            up_q       <= up_req;
            dn_q       <= dn_req;
        end
    end

    // Carries ride only on the RUN step so a set-mode edit at max never ripples.
    logic run_min;
    logic run_hour;
    logic sel_sec;
    logic sel_min;
    logic sel_hour;

    assign sel_sec  = (mode_q == SET_SEC);
    assign sel_min  = (mode_q == SET_MIN);
    assign sel_hour = (mode_q == SET_HOUR);
    assign run_min  = step_q & done_inc_sec;
    assign run_hour = run_min & done_inc_min;

    assign inc_sec   = step_q | (up_q & sel_sec);
    assign dec_sec   = dn_q & sel_sec;
    assign en_sec    = inc_sec | dec_sec;
    assign inc_min   = run_min | (up_q & sel_min);
    assign dec_min   = dn_q & sel_min;
    assign en_min    = inc_min | dec_min;
    assign inc_hour  = run_hour | (up_q & sel_hour);
    assign dec_hour  = dn_q & sel_hour;
    assign en_hour   = inc_hour | dec_hour;
    assign day_pulse = run_hour & done_inc_hour;
    assign mode      = mode_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_chain_ctrl.sv
module tb_clock_chain_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       done_inc_sec;
    logic       done_inc_min;
    logic       done_inc_hour;
    logic       en_sec, inc_sec, dec_sec;
    logic       en_min, inc_min, dec_min;
    logic       en_hour, inc_hour, dec_hour;
    logic [1:0] mode;
    logic       blink;
    logic       day_pulse;

    int checks = 0;
    int errors = 0;

    // Behavioural models of the three external counters.
    int sec_cnt = 0;
    int min_cnt = 0;
    int hour_cnt = 0;

    logic [9:0] ctl;
    assign ctl = {en_sec, inc_sec, dec_sec, en_min, inc_min, dec_min,
                  en_hour, inc_hour, dec_hour, day_pulse};

    localparam logic [9:0] V_NONE     = 10'b0000000000;
    localparam logic [9:0] V_SEC      = 10'b1100000000;
    localparam logic [9:0] V_RUN_ALL  = 10'b1101101101;
    localparam logic [9:0] V_DEC_MIN  = 10'b0001010000;
    localparam logic [9:0] V_INC_MIN  = 10'b0001100000;
    localparam logic [9:0] V_INC_HOUR = 10'b0000001100;

    assign done_inc_sec  = inc_sec & (sec_cnt == 59);
    assign done_inc_min  = inc_min & (min_cnt == 59);
    assign done_inc_hour = inc_hour & (hour_cnt == 23);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en_sec) begin
            if (inc_sec) sec_cnt <= (sec_cnt == 59) ? 0 : sec_cnt + 1;
            else if (dec_sec) sec_cnt <= (sec_cnt == 0) ? 59 : sec_cnt - 1;
        end
        if (en_min) begin
            if (inc_min) min_cnt <= (min_cnt == 59) ? 0 : min_cnt + 1;
            else if (dec_min) min_cnt <= (min_cnt == 0) ? 59 : min_cnt - 1;
        end
        if (en_hour) begin
            if (inc_hour) hour_cnt <= (hour_cnt == 23) ? 0 : hour_cnt + 1;
            else if (dec_hour) hour_cnt <= (hour_cnt == 0) ? 23 : hour_cnt - 1;
        end
    end

    clock_chain_ctrl #(
        .CNT_W(24),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(4),
        .TIMEOUT_TICKS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tick_1hz(tick_1hz),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .done_inc_sec(done_inc_sec),
        .done_inc_min(done_inc_min),
        .done_inc_hour(done_inc_hour),
        .en_sec(en_sec),
        .inc_sec(inc_sec),
        .dec_sec(dec_sec),
        .en_min(en_min),
        .inc_min(inc_min),
        .dec_min(dec_min),
        .en_hour(en_hour),
        .inc_hour(inc_hour),
        .dec_hour(dec_hour),
        .mode(mode),
        .blink(blink),
        .day_pulse(day_pulse)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cyc();
        btn_mode = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        btn_up   = 1'b1;
        tick_1hz = 1'b1;
        repeat (3) cyc();
        checks++;
        if (ctl !== V_NONE) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=%b", ctl, V_NONE);
        end
        checks++;
        if (mode !== 2'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL reset_mode got mode=%0d blink=%b exp mode=0 blink=0", mode, blink);
        end
        tick_1hz = 1'b0;
        cyc();
        reset_n = 1'b1;
        sec_cnt = 0;
        min_cnt = 0;
        hour_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (ctl !== V_NONE || mode !== 2'd0) begin
                errors++;
                $display("FAIL reset_release_spurious cyc=%0d got ctl=%b mode=%0d exp ctl=%b mode=0",
                         i, ctl, mode, V_NONE);
            end
        end
        btn_up = 1'b0;
        cyc();
    endtask

    task automatic test_run_carry();
        sec_cnt = 12;
        min_cnt = 3;
        hour_cnt = 4;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        checks++;
        if (ctl !== V_SEC) begin
            errors++;
            $display("FAIL run_tick got=%b exp=%b", ctl, V_SEC);
        end
        cyc();
        checks++;
        if (ctl !== V_NONE || sec_cnt != 13 || min_cnt != 3) begin
            errors++;
            $display("FAIL run_tick_after got ctl=%b sec=%0d min=%0d exp ctl=%b sec=13 min=3",
                     ctl, sec_cnt, min_cnt, V_NONE);
        end
        sec_cnt = 59;
        min_cnt = 59;
        hour_cnt = 23;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        checks++;
        if (ctl !== V_RUN_ALL) begin
            errors++;
            $display("FAIL run_full_carry got=%b exp=%b", ctl, V_RUN_ALL);
        end
        cyc();
        checks++;
        if (ctl !== V_NONE || sec_cnt != 0 || min_cnt != 0 || hour_cnt != 0) begin
            errors++;
            $display("FAIL run_carry_after got ctl=%b s=%0d m=%0d h=%0d exp ctl=%b s=0 m=0 h=0",
                     ctl, sec_cnt, min_cnt, hour_cnt, V_NONE);
        end
        // Ignored up/down in RUN.
        btn_up = 1'b1;
        cyc();
        btn_up = 1'b0;
        checks++;
        if (ctl !== V_NONE || mode !== 2'd0) begin
            errors++;
            $display("FAIL run_up_ignored got ctl=%b mode=%0d exp ctl=%b mode=0", ctl, mode, V_NONE);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        sec_cnt = 20;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ctl !== V_NONE) begin
            errors++;
            $display("FAIL async_reset_mid_pulse got=%b exp=%b", ctl, V_NONE);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++;
        if (sec_cnt != 20) begin
            errors++;
            $display("FAIL async_reset_no_count got sec=%0d exp sec=20", sec_cnt);
        end
    endtask

    task automatic test_set_min_down();
        sec_cnt = 7;
        min_cnt = 0;
        hour_cnt = 5;
        btn_mode = 1'b1;
        cyc();
        btn_mode = 1'b0;
        checks++;
        if (mode !== 2'd1 || blink !== 1'b1) begin
            errors++;
            $display("FAIL enter_set_hour got mode=%0d blink=%b exp mode=1 blink=1", mode, blink);
        end
        cyc();
        press_mode();
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL enter_set_min got mode=%0d exp 2", mode);
        end
        btn_down = 1'b1;
        cyc();
        checks++;
        if (ctl !== V_DEC_MIN) begin
            errors++;
            $display("FAIL set_min_down_pulse got=%b exp=%b", ctl, V_DEC_MIN);
        end
        cyc();
        checks++;
        if (ctl !== V_NONE) begin
            errors++;
            $display("FAIL set_min_down_single got=%b exp=%b", ctl, V_NONE);
        end
        btn_down = 1'b0;
        cyc();
        checks++;
        if (min_cnt != 59 || sec_cnt != 7 || hour_cnt != 5) begin
            errors++;
            $display("FAIL set_min_wrap got s=%0d m=%0d h=%0d exp s=7 m=59 h=5",
                     sec_cnt, min_cnt, hour_cnt);
        end
    endtask

    task automatic test_simultaneous();
        press_mode();
        checks++;
        if (mode !== 2'd3) begin
            errors++;
            $display("FAIL enter_set_sec got mode=%0d exp 3", mode);
        end
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            checks++;
            if (ctl !== V_NONE) begin
                errors++;
                $display("FAIL up_down_both cyc=%0d got=%b exp=%b", i, ctl, V_NONE);
            end
        end
        btn_up = 1'b0;
        btn_down = 1'b0;
        cyc();
        cyc();
        btn_mode = 1'b1;
        btn_up = 1'b1;
        cyc();
        btn_mode = 1'b0;
        checks++;
        if (mode !== 2'd0 || ctl !== V_NONE || blink !== 1'b0) begin
            errors++;
            $display("FAIL mode_beats_up got mode=%0d ctl=%b blink=%b exp mode=0 ctl=%b blink=0",
                     mode, ctl, blink, V_NONE);
        end
        cyc();
        btn_up = 1'b0;
        checks++;
        if (ctl !== V_NONE || sec_cnt != 7) begin
            errors++;
            $display("FAIL mode_beats_up_after got ctl=%b sec=%0d exp ctl=%b sec=7", ctl, sec_cnt, V_NONE);
        end
        cyc();
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic test_timeout();
        hour_cnt = 5;
        press_mode();
        pulse_tick();
        checks++;
        if (mode !== 2'd1 || blink !== 1'b0 || ctl !== V_NONE) begin
            errors++;
            $display("FAIL timeout_tick1 got mode=%0d blink=%b ctl=%b exp mode=1 blink=0 ctl=%b",
                     mode, blink, ctl, V_NONE);
        end
        cyc();
        pulse_tick();
        checks++;
        if (mode !== 2'd1 || blink !== 1'b1) begin
            errors++;
            $display("FAIL timeout_tick2 got mode=%0d blink=%b exp mode=1 blink=1", mode, blink);
        end
        cyc();
        btn_up = 1'b1;
        cyc();
        btn_up = 1'b0;
        checks++;
        if (ctl !== V_INC_HOUR) begin
            errors++;
            $display("FAIL set_hour_up got=%b exp=%b", ctl, V_INC_HOUR);
        end
        cyc();
        pulse_tick();
        checks++;
        if (mode !== 2'd1 || blink !== 1'b0) begin
            errors++;
            $display("FAIL timeout_restart got mode=%0d blink=%b exp mode=1 blink=0", mode, blink);
        end
        cyc();
        pulse_tick();
        checks++;
        if (mode !== 2'd1 || blink !== 1'b1) begin
            errors++;
            $display("FAIL timeout_tick4 got mode=%0d blink=%b exp mode=1 blink=1", mode, blink);
        end
        cyc();
        pulse_tick();
        checks++;
        if (mode !== 2'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL timeout_expire got mode=%0d blink=%b exp mode=0 blink=0", mode, blink);
        end
        cyc();
        checks++;
        if (hour_cnt != 6 || sec_cnt != 7) begin
            errors++;
            $display("FAIL timeout_frozen got h=%0d s=%0d exp h=6 s=7", hour_cnt, sec_cnt);
        end
    endtask

    task automatic test_autorepeat();
        int n_inc;
        int n_bad;
        int exp_inc;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
        exp_inc = 4;
`else
        exp_inc = 1;
`endif
        n_inc = 0;
        n_bad = 0;
        min_cnt = 10;
        press_mode();
        press_mode();
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL repeat_enter_set_min got mode=%0d exp 2", mode);
        end
        btn_up = 1'b1;
        for (int i = 0; i < 22; i++) begin
            cyc();
            if (ctl === V_INC_MIN) n_inc++;
            else if (ctl !== V_NONE) n_bad++;
        end
        btn_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (ctl === V_INC_MIN) n_inc++;
            else if (ctl !== V_NONE) n_bad++;
        end
        checks++;
        if (n_inc != exp_inc || n_bad != 0) begin
            errors++;
            $display("FAIL repeat_count got inc=%0d other=%0d exp inc=%0d other=0", n_inc, n_bad, exp_inc);
        end
        checks++;
        if (min_cnt != 10 + exp_inc) begin
            errors++;
            $display("FAIL repeat_min_value got min=%0d exp %0d", min_cnt, 10 + exp_inc);
        end
        press_mode();
        press_mode();
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL repeat_back_to_run got mode=%0d exp 0", mode);
        end
    endtask

    initial begin
        test_reset();
        test_run_carry();
        test_async_reset();
        test_set_min_down();
        test_simultaneous();
        test_timeout();
        test_autorepeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_chain_ctrl.md
# clock_chain_ctrl

Sequencer and set-mode controller for the seconds/minutes/hours `count_gate` chain of the clock. It:
- drives the `en`/`inc`/`dec` pins of three external counters;
- in RUN, advances seconds once per `tick_1hz` and ripples carries using the counters' `done_inc` flags;
- in the set modes, turns debounced up/down buttons into single-step edits of the selected field, with optional auto-repeat and an inactivity timeout back to RUN.

## Interface
Parameters:
- `CNT_W`, 24, width of the internal repeat cycle counter
- `REPEAT_DELAY`, 12_000_000, clk cycles a button must be held before the first auto-repeat step
- `REPEAT_PERIOD`, 3_000_000, clk cycles between auto-repeat steps
- `TIMEOUT_TICKS`, 10, `tick_1hz` pulses with no button activity before a set mode returns to RUN (4-bit counter)

Ports:
- `clk` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `tick_1hz` in 1: one-cycle pulse, once per second
- `btn_mode` / `btn_up` / `btn_down` in 1 each: debounced, synchronous level inputs, 1 = pressed
- `done_inc_sec` / `done_inc_min` / `done_inc_hour` in 1 each: counters' `done_inc` (combinational: `inc & count==max`)
- `en_sec` / `inc_sec` / `dec_sec` out 1 each: seconds counter control
- `en_min` / `inc_min` / `dec_min` out 1 each: minutes counter control
- `en_hour` / `inc_hour` / `dec_hour` out 1 each: hours counter control
- `mode` out 2: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
- `blink` out 1: display blink phase for the selected field
- `day_pulse` out 1: one-cycle pulse when hours wrap in RUN

## Operation
- Reset values:
  - all outputs are 0 and `mode`=RUN;
  - button history registers, repeat counter and timeout counter are cleared.
- Edge detect:
  - each button is registered once;
  - the press event is `btn & ~btn_q`.
- Mode FSM:
  - each `btn_mode` press event advances the mode RUN→SET_HOUR→SET_MIN→SET_SEC→RUN;
  - the timeout counter reaching `TIMEOUT_TICKS` in any set mode forces RUN;
  - any button press event or repeat step clears the timeout counter;
  - entering RUN also clears the timeout counter.
- RUN:
  - `step_q` is a registered copy of `tick_1hz`;
  - `en_sec`=`inc_sec`=`step_q`;
  - `inc_min`=`en_min`=`step_q & done_inc_sec`;
  - `inc_hour`=`en_hour`=`inc_min & done_inc_min`;
  - `day_pulse`=`inc_hour & done_inc_hour`;
  - all `dec_*` are 0; up/down are ignored.
- SET_x:
  - timekeeping is frozen; `tick_1hz` only toggles `blink` and counts the timeout;
  - an up step drives the selected field's `en`/`inc` high for exactly one cycle;
  - a down step drives the selected field's `en`/`dec` high for exactly one cycle;
  - no carry propagates to other fields; wrap at max or 0 is done by the counter itself;
  - `day_pulse` stays 0.
- Simultaneous events:
  - up and down both pressed: no step, and the repeat counter is held at 0;
  - a mode press in the same cycle as an up/down press: the mode change wins and the step is dropped.
- `blink` is forced to 0 in RUN and set to 1 on entry to any set mode.

## Timing
- Counter-control pulses are one cycle long, and asserted in the cycle after:
  - the `tick_1hz` pulse (RUN), or
  - the button rising edge (set modes).
- Carry outputs are combinational from the registered step and the `done_inc_*` inputs; there is no extra latency across the chain.
- Mode changes take effect in the cycle after the press event; `mode` is registered.
- A reset assertion mid-pulse clears all outputs immediately (asynchronously).

## Configuration
- `CLOCK_CTRL_AUTOREPEAT_EN` defined:
  - while exactly one of up/down is held in a set mode, the repeat counter counts clk cycles;
  - the first repeat step occurs at `REPEAT_DELAY`, then one step every `REPEAT_PERIOD`;
  - the counter clears on release.
- Undefined:
  - only press events produce steps;
  - the repeat counter logic is absent.

## Test plan
1. Reset while `btn_up`=1 and `tick_1hz`=1 -> all outputs 0, `mode`=0; releasing reset gives no spurious step.
2. RUN, model counters at sec=59, min=59, hour=23, pulse `tick_1hz` -> next cycle `inc_sec`, `inc_min`, `inc_hour` and `day_pulse` all 1 for one cycle; `dec_*` stay 0.
3. Press `btn_mode` twice, then `btn_down` once -> `mode`=2; a single `en_min`/`dec_min` pulse; seconds and hours untouched; min=0 wraps to 59 via the counter.
4. In SET_SEC, `btn_up` and `btn_down` rise in the same cycle -> no step; then `btn_mode` together with `btn_up` -> `mode`=0 with no `inc_sec`.
5. `TIMEOUT_TICKS`=3, in SET_HOUR with no buttons, 3 tick pulses -> `mode`=0 and `blink`=0; a button press between ticks restarts the count.
6. With `CLOCK_CTRL_AUTOREPEAT_EN`, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=4, hold `btn_up` 22 cycles in SET_MIN -> exactly 4 `inc_min` pulses (press, then cycles 10, 14, 18); without the macro -> exactly 1.
